// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and pipeline types for the VGA scan reader.
// Framebuffer geometry depends on VGA_PIXEL_DOUBLE_EN:
//   defined     -> 320x240 framebuffer, each word shown as a 2x2 block
//   not defined -> 640x480 framebuffer, one word per pixel
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks.
  localparam logic [9:0] H_VISIBLE  = 10'd640;
  localparam logic [9:0] H_FP_END   = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] H_TOTAL    = 10'd800;
  localparam logic [9:0] H_LAST     = 10'd799;

  // Vertical timing, in lines.
  localparam logic [9:0] V_VISIBLE  = 10'd480;
  localparam logic [9:0] V_FP_END   = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;
  localparam logic [9:0] V_TOTAL    = 10'd525;
  localparam logic [9:0] V_LAST     = 10'd524;
  localparam logic [9:0] V_LAST_VIS = 10'd479;

`ifdef VGA_PIXEL_DOUBLE_EN
  localparam logic [19:0] FB_WIDTH  = 20'd320;
  localparam logic [19:0] FB_HEIGHT = 20'd240;
`else
  localparam logic [19:0] FB_WIDTH  = 20'd640;
  localparam logic [19:0] FB_HEIGHT = 20'd480;
`endif
  localparam logic [19:0] FB_WORDS  = 20'(FB_WIDTH * FB_HEIGHT);

  // Per-pixel control bits carried alongside the SRAM read.
  typedef struct packed {
    logic blank;
    logic hs;
    logic vs;
    logic first;
  } pix_ctl_t;

  // Value held by every delay stage while idle or in reset: blanked, syncs inactive.
  localparam pix_ctl_t CTL_IDLE = '{blank: 1'b1, hs: 1'b1, vs: 1'b1, first: 1'b0};

endpackage

// File: rtl/vga_scan_reader_if.sv
// Bundle of the SRAM scan port and the VGA pin outputs of vga_scan_reader.
// master = the scan reader, slave = SRAM controller / board pins side.
interface vga_scan_reader_if;

  // Scan-port contract (no valid/ready): the reader presents a new registered
  // vram_scan_addr every clock; the controller must return the matching
  // vram_scan_data exactly READ_LAT clocks later. Data is don't-care whenever
  // the corresponding pixel is blanked.
  logic [19:0] vram_scan_addr;
  logic [15:0] vram_scan_data;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_start;

  modport master (
    output vram_scan_addr,
    input  vram_scan_data,
    output vga_r,
    output vga_g,
    output vga_b,
    output vga_hs,
    output vga_vs,
    output frame_start
  );

  modport slave (
    input  vram_scan_addr,
    output vram_scan_data,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vga_hs,
    input  vga_vs,
    input  frame_start
  );

endinterface

// File: rtl/vga_scan_reader_sync.sv
// vga_sync_counter: free-running 800x525 h/v counters with raw (undelayed)
// visible, sync and first-pixel decodes for 640x480@60 Hz.
module vga_sync_counter
  import vga_timing_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [9:0] h_cnt_o,
  output logic [9:0] v_cnt_o,
  output logic       visible_o,
  output logic       hs_raw_o,
  output logic       vs_raw_o,
  output logic       first_pixel_o,
  output logic       line_end_o,
  output logic       frame_end_o
);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  // Next-state: h wraps at 799, v advances on each h wrap and wraps at 524.
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end
  end

  // Counter registers; reset restarts the frame at (0,0).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Raw decodes of the current counter position.
  always_comb begin
    visible_o     = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);
    hs_raw_o      = !((h_cnt_q >= H_FP_END) && (h_cnt_q < H_SYNC_END));
    vs_raw_o      = !((v_cnt_q >= V_FP_END) && (v_cnt_q < V_SYNC_END));
    first_pixel_o = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    line_end_o    = (h_cnt_q == H_LAST);
    frame_end_o   = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;

endmodule

// File: rtl/vga_scan_reader.sv
// vga_scan_reader: reads a framebuffer through the SRAM controller scan port
// and drives 640x480@60 Hz VGA with 4:4:4 RGB and aligned active-low syncs.
// Counter position -> pins latency is READ_LAT+1 clocks: one for the address
// register, READ_LAT for the SRAM; the last control stage is the output register.
// Optional build macro VGA_PIXEL_DOUBLE_EN selects a 320x240 framebuffer
// displayed with 2x2 pixel doubling; otherwise the framebuffer is 640x480.
module vga_scan_reader
  import vga_timing_pkg::*;
#(
  parameter logic [19:0] VRAM_BASE = 20'h00000,
  parameter int          READ_LAT  = 1
)(
  input  logic              clk_25mhz,
  input  logic              rst,
  vga_scan_reader_if.master bus
);

  // Raw timing from the counter block.
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       visible;
  logic       hs_raw;
  logic       vs_raw;
  logic       first_pixel;
  logic       line_end;
  logic       frame_end;

  vga_sync_counter u_sync (
    .clk_i         (clk_25mhz),
    .rst_i         (rst),
    .h_cnt_o       (h_cnt),
    .v_cnt_o       (v_cnt),
    .visible_o     (visible),
    .hs_raw_o      (hs_raw),
    .vs_raw_o      (vs_raw),
    .first_pixel_o (first_pixel),
    .line_end_o    (line_end),
    .frame_end_o   (frame_end)
  );

  // ---------------------------------------------------------------------------
  // Address generation: incremental line base plus column offset, no multiplier.
  // VRAM_BASE + FB_WORDS - 1 must fit in 20 bits; nothing wraps the address.
  // ---------------------------------------------------------------------------
  logic [19:0] line_base_q, line_base_d;
  logic [19:0] addr_q, addr_d;
  logic [19:0] col_off;

  // Line base steps to the next framebuffer row at the end of a visible line
  // and returns to the frame start at the very last clock of the frame.
  always_comb begin
    line_base_d = line_base_q;
    if (line_end) begin
      if (frame_end) begin
        line_base_d = VRAM_BASE;
`ifdef VGA_PIXEL_DOUBLE_EN
      end else if (v_cnt[0] && (v_cnt < V_LAST_VIS)) begin
`else
      end else if (v_cnt < V_LAST_VIS) begin
`endif
        line_base_d = line_base_q + FB_WIDTH;
      end
    end
  end

  // Address for the pixel at the current counter; parked at VRAM_BASE in blanking.
  always_comb begin
`ifdef VGA_PIXEL_DOUBLE_EN
    col_off = {11'd0, h_cnt[9:1]};
`else
    col_off = {10'd0, h_cnt};
`endif
    addr_d = visible ? (line_base_q + col_off) : VRAM_BASE;
  end

  // Line base and registered scan address.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      line_base_q <= VRAM_BASE;
      addr_q      <= VRAM_BASE;
    end else begin
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control delay line: READ_LAT stages here, the final stage is the output
  // register below, so blank/sync/first arrive with the pixel they describe.
  // Blanking travels with the pixel, so no stale data reaches col 640 / row 480.
  // ---------------------------------------------------------------------------
  pix_ctl_t ctl_d;
  pix_ctl_t ctl_q [READ_LAT];
  pix_ctl_t ctl_last;

  // Pack the raw decodes for the current counter position.
  always_comb begin
    ctl_d.blank = !visible;
    ctl_d.hs    = hs_raw;
    ctl_d.vs    = vs_raw;
    ctl_d.first = first_pixel;
  end

  // Shift register matching the SRAM read latency.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        ctl_q[i] <= CTL_IDLE;
      end
    end else begin
      ctl_q[0] <= ctl_d;
      for (int i = 1; i < READ_LAT; i++) begin
        ctl_q[i] <= ctl_q[i-1];
      end
    end
  end

  assign ctl_last = ctl_q[READ_LAT-1];

  // ---------------------------------------------------------------------------
  // Output register: RGB565 -> 4:4:4 (top bits of each field), syncs, frame pulse.
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_q, rgb_d;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;

  // Colour mapping; returned data is ignored while the pixel is blanked.
  always_comb begin
    rgb_d = 12'h000;
    if (!ctl_last.blank) begin
      rgb_d = {bus.vram_scan_data[15:12], bus.vram_scan_data[10:7], bus.vram_scan_data[4:1]};
    end
  end

  // Pin registers; the final control stage lands here together with the RGB.
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= ctl_last.hs;
      vs_q  <= ctl_last.vs;
      fs_q  <= ctl_last.first;
    end
  end

  // Low bit of each RGB565 field is dropped by the 4:4:4 mapping.
`ifdef VGA_PIXEL_DOUBLE_EN
  logic unused_bits;
  assign unused_bits = ^{bus.vram_scan_data[11], bus.vram_scan_data[5],
                         bus.vram_scan_data[0], h_cnt[0]};
`else
  logic unused_bits;
  assign unused_bits = ^{bus.vram_scan_data[11], bus.vram_scan_data[5],
                         bus.vram_scan_data[0]};
`endif

  assign bus.vram_scan_addr = addr_q;
  assign bus.vga_r          = rgb_q[11:8];
  assign bus.vga_g          = rgb_q[7:4];
  assign bus.vga_b          = rgb_q[3:0];
  assign bus.vga_hs         = hs_q;
  assign bus.vga_vs         = vs_q;
  assign bus.frame_start    = fs_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Bench for vga_scan_reader: frame-position model, per-cycle compare, directed
// literal checks, sync width/period checks, mid-frame reset.
// Long stretches of the frame are skipped by briefly overriding the line counter
// and line base to a consistent later row.
module tb_vga_scan_reader;

  localparam logic [19:0] BASE = 20'h10000;

`ifdef VGA_PIXEL_DOUBLE_EN
  localparam logic [19:0] L_ROW1   = 20'h10000;
  localparam logic [19:0] L_P24    = 20'h10281;
  localparam logic [19:0] L_P35    = 20'h10281;
  localparam logic [19:0] L_LAST   = 20'h22BFF;
  localparam logic [19:0] L_P5     = 20'h10002;
  localparam logic [19:0] LB478    = BASE + 20'd76480;
  localparam logic [19:0] LB199    = BASE + 20'd31680;
  localparam logic [11:0] L_RGB5   = 12'h001;
  localparam logic [11:0] L_RGB639 = 12'h02F;
`else
  localparam logic [19:0] L_ROW1   = 20'h10280;
  localparam logic [19:0] L_P24    = 20'h10A02;
  localparam logic [19:0] L_P35    = 20'h10C83;
  localparam logic [19:0] L_LAST   = 20'h5AFFF;
  localparam logic [19:0] L_P5     = 20'h10005;
  localparam logic [19:0] LB478    = BASE + 20'd305920;
  localparam logic [19:0] LB199    = BASE + 20'd127360;
  localparam logic [11:0] L_RGB5   = 12'h002;
  localparam logic [11:0] L_RGB639 = 12'h04F;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  vga_scan_reader_if bus ();

  vga_scan_reader #(.VRAM_BASE(BASE), .READ_LAT(1)) dut (
    .clk_25mhz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  // ---------------- SRAM model: data ready one clock after the address ----------
  logic ffff_mode = 1'b0;
  always @(negedge clk) begin
    bus.vram_scan_data = ffff_mode ? 16'hFFFF : bus.vram_scan_addr[15:0];
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds {v,h} of the last two counter positions consumed by clock edges.
  logic [19:0] exp_q[$];
  int m_h = 0;
  int m_v = 0;
  int jump_seq = 0;
  int jump_seen = 0;
  int jump_v = 0;

  function automatic logic [19:0] exp_addr(input logic [19:0] p);
    int h;
    int v;
    h = int'(p[9:0]);
    v = int'(p[19:10]);
    if (h < 640 && v < 480) begin
`ifdef VGA_PIXEL_DOUBLE_EN
      return BASE + 20'((v / 2) * 320 + h / 2);
`else
      return BASE + 20'(v * 640 + h);
`endif
    end
    return BASE;
  endfunction

  function automatic logic [11:0] exp_rgb(input logic [19:0] p);
    logic [15:0] d;
    logic [19:0] a;
    if (!(p[9:0] < 10'd640 && p[19:10] < 10'd480)) return 12'h000;
    a = exp_addr(p);
    d = ffff_mode ? 16'hFFFF : a[15:0];
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

  // Advance the frame position once per clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_h = 0;
      m_v = 0;
      jump_seen = jump_seq;
    end else begin
      if (jump_seq != jump_seen) begin
        m_v = jump_v;
        jump_seen = jump_seq;
      end
      exp_q.push_back({10'(m_v), 10'(m_h)});
      if (exp_q.size() > 2) void'(exp_q.pop_front());
      if (m_h == 799) begin
        m_h = 0;
        m_v = (m_v == 524) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    int n;
    int cyc;
    int hs_low;
    int vs_low;
    int last_fall;
    logic prev_hs;
    logic [19:0] p;
    logic [19:0] ea;
    logic [11:0] erg;
    logic ehs, evs, efs;
    cyc = 0; hs_low = 0; vs_low = 0; last_fall = -1; prev_hs = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      n = exp_q.size();
      ea  = (n >= 1) ? exp_addr(exp_q[n-1]) : BASE;
      erg = 12'h000; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
      if (n >= 2) begin
        p   = exp_q[n-2];
        erg = exp_rgb(p);
        ehs = !(p[9:0] >= 10'd656 && p[9:0] < 10'd752);
        evs = !(p[19:10] >= 10'd490 && p[19:10] < 10'd492);
        efs = (p == 20'd0);
      end
      check("addr", 32'(bus.vram_scan_addr), 32'(ea));
      check("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(erg));
      check("hs", 32'(bus.vga_hs), 32'(ehs));
      check("vs", 32'(bus.vga_vs), 32'(evs));
      check("frame_start", 32'(bus.frame_start), 32'(efs));
      if (rst) begin
        hs_low = 0; vs_low = 0; last_fall = -1; prev_hs = 1'b1;
      end else begin
        if (!bus.vga_hs) hs_low++;
        else if (hs_low != 0) begin check("hs_width", 32'(hs_low), 32'd96); hs_low = 0; end
        if (!bus.vga_vs) vs_low++;
        else if (vs_low != 0) begin check("vs_width", 32'(vs_low), 32'd1600); vs_low = 0; end
        if (prev_hs && !bus.vga_hs) begin
          if (last_fall >= 0) check("hs_period", 32'(cyc - last_fall), 32'd800);
          last_fall = cyc;
        end
        prev_hs = bus.vga_hs;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic jump_to(input int v, input logic [19:0] lb);
    case (v)
      478: begin force dut.u_sync.v_cnt_q = 10'd478; force dut.line_base_q = LB478; end
      default: begin force dut.u_sync.v_cnt_q = 10'd199; force dut.line_base_q = LB199; end
    endcase
    jump_v = v;
    jump_seq++;
    check("jump_lb_arg", 32'(lb), 32'(v == 478 ? LB478 : LB199));
  endtask

  task automatic unjump();
    release dut.u_sync.v_cnt_q;
    release dut.line_base_q;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    bus.vram_scan_data = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    // Frame 0, rows 0..5, data = address.
    for (int e = 1; e <= 4700; e++) begin
      @(negedge clk); #1;
      if (e == 1)    check("fs_e1", 32'(bus.frame_start), 32'd0);
      if (e == 2)    check("fs_e2", 32'(bus.frame_start), 32'd1);
      if (e == 3)    check("fs_e3", 32'(bus.frame_start), 32'd0);
      if (e == 6)    check("addr_p5", 32'(bus.vram_scan_addr), 32'(L_P5));
      if (e == 7)    check("rgb_p5", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(L_RGB5));
      if (e == 641)  check("rgb_p639", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(L_RGB639));
      if (e == 642)  check("addr_park", 32'(bus.vram_scan_addr), 32'(BASE));
      if (e == 657)  check("hs_pre", 32'(bus.vga_hs), 32'd1);
      if (e == 658)  check("hs_fall", 32'(bus.vga_hs), 32'd0);
      if (e == 753)  check("hs_end", 32'(bus.vga_hs), 32'd0);
      if (e == 754)  check("hs_rise", 32'(bus.vga_hs), 32'd1);
      if (e == 801)  check("addr_row1", 32'(bus.vram_scan_addr), 32'(L_ROW1));
      if (e == 3203) check("addr_p24", 32'(bus.vram_scan_addr), 32'(L_P24));
      if (e == 4004) check("addr_p35", 32'(bus.vram_scan_addr), 32'(L_P35));
    end

    // Skip to row 478 (next position (700,478)), all-ones data.
    ffff_mode = 1'b1;
    jump_to(478, LB478);
    for (int f = 1; f <= 37600; f++) begin
      @(negedge clk); #1;
      if (f == 2)     unjump();
      if (f == 740)   check("addr_last", 32'(bus.vram_scan_addr), 32'(L_LAST));
      if (f == 741)   check("rgb_last_vis", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFF);
      if (f == 742)   check("rgb_col640", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
      if (f == 902)   check("rgb_row480", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
      if (f == 8901)  check("vs_pre", 32'(bus.vga_vs), 32'd1);
      if (f == 8902)  check("vs_fall", 32'(bus.vga_vs), 32'd0);
      if (f == 10501) check("vs_end", 32'(bus.vga_vs), 32'd0);
      if (f == 10502) check("vs_rise", 32'(bus.vga_vs), 32'd1);
      if (f == 36901) check("fs_pre", 32'(bus.frame_start), 32'd0);
      if (f == 36902) check("fs_frame1", 32'(bus.frame_start), 32'd1);
      if (f == 36902) check("rgb_frame1", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'hFFF);
      if (f == 36903) check("fs_post", 32'(bus.frame_start), 32'd0);
    end

    // Skip to row 199 (next position (700,199)), data = address, reset at (300,200).
    ffff_mode = 1'b0;
    jump_to(199, LB199);
    for (int r = 1; r <= 400; r++) begin
      @(negedge clk); #1;
      if (r == 2) unjump();
    end
    rst = 1'b1;
    #1;
    check("rst_addr", 32'(bus.vram_scan_addr), 32'(BASE));
    check("rst_rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'h000);
    check("rst_hs", 32'(bus.vga_hs), 32'd1);
    check("rst_vs", 32'(bus.vga_vs), 32'd1);
    check("rst_fs", 32'(bus.frame_start), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    for (int g = 1; g <= 2400; g++) begin
      @(negedge clk); #1;
      if (g == 1) check("rfs_e1", 32'(bus.frame_start), 32'd0);
      if (g == 2) check("rfs_e2", 32'(bus.frame_start), 32'd1);
      if (g == 6) check("raddr_p5", 32'(bus.vram_scan_addr), 32'(L_P5));
      if (g == 7) check("rrgb_p5", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(L_RGB5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
